// File: rtl/mem_ram_init.sv
// mem_ram_init: single-clock simple-dual-port RAM (one write, one read port)
// with per-byte write enables, selectable read latency (RD_LAT = 1 or 2),
// selectable read-during-write policy (RDW_MODE) and a hardware init sweep
// that loads INIT_VAL into every word after reset or on init_req.
//
// Optional feature: define MEM_PARITY_EN to store one even-parity bit per
// byte and flag par_err on reads whose stored parity does not match.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   init_req  pulse, starts an init sweep (honoured only while idle)
//   busy      init sweep in progress; all accesses are ignored
//   wr_en     write strobe
//   wr_be     byte enables, bit b covers wr_data[8b+7:8b]
//   wr_addr   write address
//   wr_data   write data
//   rd_en     read strobe
//   rd_addr   read address
//   rd_data   registered read data, holds between reads
//   rd_valid  one-cycle pulse per accepted read
//   par_err   parity error, only ever high together with rd_valid
module mem_ram_init #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                RD_LAT   = 1,
  parameter int                RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  par_err
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // Even parity per byte: bit b is the XOR of byte b.
  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  // An init_req cycle also drops any access presented alongside it.
  logic acc_ok, wr_acc, rd_acc, rdw_fwd;
  assign acc_ok  = !busy_q && !init_req;
  assign wr_acc  = wr_en && acc_ok;
  assign rd_acc  = rd_en && acc_ok;
  assign rdw_fwd = (RDW_MODE == 1) && wr_acc && (wr_addr == rd_addr);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Asynchronous array read; same-address bypass merges the enabled bytes.
  logic [DATA_W-1:0] rd_word;
  always_comb begin
    rd_word = mem[rd_addr];
    if (rdw_fwd)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
  end

  logic rd_perr;
`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par, init_par, rd_par;

  assign wr_par   = byte_par(wr_data);
  assign init_par = byte_par(INIT_VAL);

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_mem[cnt_q] <= init_par;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) par_mem[wr_addr][b] <= wr_par[b];
    end
  end

  always_comb begin
    rd_par = par_mem[rd_addr];
    if (rdw_fwd)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) rd_par[b] = wr_par[b];
  end

  assign rd_perr = |(byte_par(rd_word) ^ rd_par);
`else
  assign rd_perr = 1'b0;
`endif

  // Stage 1: array read register
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              perr_p1_q, perr_p1_d;

  always_comb begin
    vld_p1_d  = rd_acc;
    data_p1_d = rd_acc ? rd_word : data_p1_q;
    perr_p1_d = rd_acc && rd_perr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      perr_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      perr_p1_q <= perr_p1_d;
    end
  end

  // Stage 2: optional output register
  if (RD_LAT == 2) begin : g_lat2
    logic              vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    logic              perr_p2_q, perr_p2_d;

    always_comb begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
      perr_p2_d = perr_p1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q  <= 1'b0;
        data_p2_q <= '0;
        perr_p2_q <= 1'b0;
      end else begin
        vld_p2_q  <= vld_p2_d;
        data_p2_q <= data_p2_d;
        perr_p2_q <= perr_p2_d;
      end
    end

    assign rd_valid = vld_p2_q;
    assign rd_data  = data_p2_q;
    assign par_err  = perr_p2_q;
  end else begin : g_lat1
    assign rd_valid = vld_p1_q;
    assign rd_data  = data_p1_q;
    assign par_err  = perr_p1_q;
  end

endmodule

// File: tb/tb_mem_ram_init.sv
// Directed testbench for mem_ram_init. Three instances share one stimulus:
//   u_a: defaults (RD_LAT=1, RDW_MODE=0, INIT_VAL=0)
//   u_b: RDW_MODE=1, INIT_VAL=16'hA5C3
//   u_c: RD_LAT=2
module tb_mem_ram_init;

  localparam logic [15:0] IV_B = 16'hA5C3;

  logic        clk, rst_n, init_req, wr_en, rd_en;
  logic [1:0]  wr_be;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] rd_data_a, rd_data_b, rd_data_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic        par_err_a, par_err_b, par_err_c;

  int tests = 0;
  int fails = 0;

  mem_ram_init u_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_a),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .par_err(par_err_a)
  );

  mem_ram_init #(.RDW_MODE(1), .INIT_VAL(IV_B)) u_b (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_b),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .par_err(par_err_b)
  );

  mem_ram_init #(.RD_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_c),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .rd_valid(rd_valid_c), .par_err(par_err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vld = {a@1, b@1, c@1, a@2, c@2}; pe = {a@1, b@1, c@2}
  typedef struct packed {
    logic [4:0]  vld;
    logic [15:0] da;
    logic [15:0] db;
    logic [15:0] dc;
    logic [2:0]  pe;
  } obs_t;

  function automatic obs_t mk_exp(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] c);
    obs_t e;
    e.vld = 5'b11001;
    e.da  = a;
    e.db  = b;
    e.dc  = c;
    e.pe  = 3'b000;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_en = 1'b0;
  endtask

  // Single read; captures both cycles after rd_en so latency is observable.
  task automatic do_read(input logic [2:0] a, output obs_t o);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    rd_en = 1'b0;
    o.vld[4] = rd_valid_a; o.vld[3] = rd_valid_b; o.vld[2] = rd_valid_c;
    o.da = rd_data_a; o.db = rd_data_b;
    o.pe[2] = par_err_a; o.pe[1] = par_err_b;
    cyc();
    o.vld[1] = rd_valid_a; o.vld[0] = rd_valid_c;
    o.dc = rd_data_c; o.pe[0] = par_err_c;
  endtask

  task automatic test_reset();
    int n, vseen;
    #3 rst_n = 1'b0;
    cyc(); cyc();
    tests++;
    if ({busy_a, busy_b, busy_c} !== 3'b111) begin
      fails++; $display("FAIL reset_busy got=%b exp=111", {busy_a, busy_b, busy_c});
    end
    tests++;
    if ({rd_valid_a, rd_valid_b, rd_valid_c, par_err_a, par_err_b, par_err_c} !== 6'b0 ||
        {rd_data_a, rd_data_b, rd_data_c} !== 48'h0) begin
      fails++; $display("FAIL reset_outputs got vld=%b pe=%b data=%h %h %h exp all 0",
        {rd_valid_a, rd_valid_b, rd_valid_c}, {par_err_a, par_err_b, par_err_c},
        rd_data_a, rd_data_b, rd_data_c);
    end
    rd_en = 1'b1; rd_addr = 3'd0;
    rst_n = 1'b1;
    n = 0; vseen = 0;
    while (busy_a && n < 20) begin
      cyc(); n++;
      if (rd_valid_a || rd_valid_b || rd_valid_c) vseen++;
    end
    rd_en = 1'b0;
    cyc();
    if (rd_valid_a || rd_valid_b || rd_valid_c) vseen++;
    tests++;
    if (n != 8) begin
      fails++; $display("FAIL reset_busy_len got=%0d exp=8", n);
    end
    tests++;
    if ({busy_a, busy_b, busy_c} !== 3'b000) begin
      fails++; $display("FAIL reset_busy_end got=%b exp=000", {busy_a, busy_b, busy_c});
    end
    tests++;
    if (vseen != 0) begin
      fails++; $display("FAIL reset_rd_during_busy got=%0d valids exp=0", vseen);
    end
  endtask

  task automatic test_init_read();
    obs_t o, e;
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), o);
      e = mk_exp(16'h0000, IV_B, 16'h0000);
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL init_read addr=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_byte_en();
    obs_t o, e;
    do_write(3'd3, 16'hABCD, 2'b01);
    do_write(3'd3, 16'h12FF, 2'b10);
    do_write(3'd3, 16'hFFFF, 2'b00);
    do_read(3'd3, o);
    e = mk_exp(16'h12CD, 16'h12CD, 16'h12CD);
    tests++;
    if (o !== e) begin
      fails++; $display("FAIL byte_en got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_rdw();
    obs_t o, e;
    do_write(3'd5, 16'h1358, 2'b11);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h79CA; wr_be = 2'b11;
    do_read(3'd5, o);
    wr_en = 1'b0;
    e = mk_exp(16'h1358, 16'h79CA, 16'h1358);
    tests++;
    if (o !== e) begin
      fails++; $display("FAIL rdw_full got=%h exp=%h", o, e);
    end
    do_read(3'd5, o);
    e = mk_exp(16'h79CA, 16'h79CA, 16'h79CA);
    tests++;
    if (o !== e) begin
      fails++; $display("FAIL rdw_after got=%h exp=%h", o, e);
    end
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00FF; wr_be = 2'b01;
    do_read(3'd5, o);
    wr_en = 1'b0;
    e = mk_exp(16'h79CA, 16'h79FF, 16'h79CA);
    tests++;
    if (o !== e) begin
      fails++; $display("FAIL rdw_merge got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [8];
    int cvld;
    for (int i = 0; i < 8; i++) begin
      v[i] = 16'h1000 + 16'(i) * 16'h0111;
      do_write(3'(i), v[i], 2'b11);
    end
    cvld = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        rd_en = 1'b1; rd_addr = 3'(k);
      end else begin
        rd_en = 1'b0;
      end
      cyc();
      tests++;
      if (rd_valid_a !== (k < 8) || rd_valid_b !== (k < 8) ||
          rd_data_a !== v[(k < 8) ? k : 7] || rd_data_b !== v[(k < 8) ? k : 7]) begin
        fails++; $display("FAIL b2b_lat1 k=%0d got v=%b%b d=%h %h exp v=%b d=%h",
          k, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b, (k < 8), v[(k < 8) ? k : 7]);
      end
      tests++;
      if (rd_valid_c !== (k >= 1 && k <= 8) ||
          (k >= 1 && rd_data_c !== v[(k <= 8) ? k - 1 : 7])) begin
        fails++; $display("FAIL b2b_lat2 k=%0d got v=%b d=%h exp v=%b d=%h",
          k, rd_valid_c, rd_data_c, (k >= 1 && k <= 8), v[(k >= 1 && k <= 8) ? k - 1 : 7]);
      end
      if (rd_valid_c) cvld++;
    end
    tests++;
    if (cvld != 8) begin
      fails++; $display("FAIL b2b_lat2_count got=%0d exp=8", cvld);
    end
  endtask

  task automatic test_init_req();
    obs_t o, e;
    int n, vseen;
    init_req = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hDEAD; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 3'd1;
    cyc();
    init_req = 1'b0;
    vseen = (rd_valid_a || rd_valid_b) ? 1 : 0;
    n = 0;
    while (busy_a && n < 20) begin
      wr_addr = 3'(n); wr_data = 16'hBEEF;
      cyc(); n++;
      if (rd_valid_a || rd_valid_b || rd_valid_c) vseen++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tests++;
    if (n != 8) begin
      fails++; $display("FAIL init_req_busy_len got=%0d exp=8", n);
    end
    tests++;
    if (vseen != 0) begin
      fails++; $display("FAIL init_req_rd_dropped got=%0d valids exp=0", vseen);
    end
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), o);
      e = mk_exp(16'h0000, IV_B, 16'h0000);
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL init_req_read addr=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int n;
    do_write(3'd6, 16'h6666, 2'b11);
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy_a, busy_b, busy_c} !== 3'b111 || {rd_data_a, rd_data_b, rd_data_c} !== 48'h0) begin
      fails++; $display("FAIL mid_reset_state got busy=%b data=%h %h %h exp busy=111 data 0",
        {busy_a, busy_b, busy_c}, rd_data_a, rd_data_b, rd_data_c);
    end
    cyc(); cyc();
    rst_n = 1'b1;
    n = 0;
    while (busy_a && n < 20) begin
      cyc(); n++;
    end
    tests++;
    if (n != 8) begin
      fails++; $display("FAIL mid_reset_busy_len got=%0d exp=8", n);
    end
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), o);
      e = mk_exp(16'h0000, IV_B, 16'h0000);
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL mid_reset_read addr=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_parity();
    obs_t o;
`ifdef MEM_PARITY_EN
    u_a.mem[2] = u_a.mem[2] ^ 16'h0001;
    do_read(3'd2, o);
    tests++;
    if (o.vld[4] !== 1'b1 || o.pe !== 3'b100 || o.da !== 16'h0001) begin
      fails++; $display("FAIL parity_flip got vld=%b pe=%b d=%h exp vld=1 pe=100 d=0001",
        o.vld[4], o.pe, o.da);
    end
    do_read(3'd3, o);
    tests++;
    if (o.pe !== 3'b000) begin
      fails++; $display("FAIL parity_clean got pe=%b exp=000", o.pe);
    end
`else
    do_read(3'd2, o);
    tests++;
    if (o.pe !== 3'b000 || {par_err_a, par_err_b, par_err_c} !== 3'b000) begin
      fails++; $display("FAIL parity_off got pe=%b now=%b exp 0", o.pe,
        {par_err_a, par_err_b, par_err_c});
    end
`endif
  endtask

  initial begin
    rst_n = 1'b1; init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_be = 2'b00; wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 16'h0000;
    test_reset();
    test_init_read();
    test_byte_en();
    test_rdw();
    test_back_to_back();
    test_init_req();
    test_reset_mid();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
